ysyx_22040632_mem_arbiter: RTL
==============================

Name: ysyx_22040632_mem_arbiter

Overview:
Shares the single cache-side memory port (rw_* burst interface feeding the AXI master) between the icache (read-only) and the dcache (read/write, including fence write-back and uncacheable accesses). It grants one owner per transaction and holds the grant until the transaction completes. It also enforces an anti-starvation limit and monitors beat count and timeout per transaction.

Parameters:
MAX_CONSEC, 4, consecutive dcache grants allowed while the icache is waiting.
TIMEOUT, 4096, cycles an owner may hold the port before err_timeout is set.
AW, 32, address width.
DW, 64, data width.

Ports:
clk  in  1  clock
rrst  in  1  asynchronous, active-high reset
i_rw_valid  in  1  icache request
i_rw_addr  in  AW  icache address
i_rw_size  in  3  icache beat size
i_rw_len  in  8  icache burst length minus 1
i_rw_ready  out  1  icache transaction done (1-cycle pulse)
i_r_hs  out  1  icache read-beat strobe
i_r_last  out  1  icache last read beat
d_rw_valid  in  1  dcache request
d_rw_req  in  1  dcache direction (REQ_READ/REQ_WRITE)
d_rw_addr  in  AW  dcache address
d_rw_size  in  3  dcache beat size
d_rw_len  in  8  dcache burst length minus 1
d_rw_w_data  in  DW  dcache write data
d_w_strb  in  DW/8  dcache write strobe
d_w_last  in  1  dcache last write beat
d_rw_ready  out  1  dcache transaction done
d_r_hs  out  1  dcache read-beat strobe
d_r_last  out  1  dcache last read beat
d_w_hs  out  1  dcache write-beat strobe
d_axi_write_ahead  out  1  dcache write-address-phase indication
data_read  out  DW  read data, broadcast to both caches
m_rw_valid / m_rw_req / m_rw_addr / m_rw_size / m_rw_len / m_rw_w_data / m_w_strb / m_w_last  out  downstream copies of the owner's request
m_rw_ready / m_r_hs / m_r_last / m_w_hs / m_axi_write_ahead / m_data_read  in  downstream responses
err_clr  in  1  clears sticky errors
err_timeout  out  1  sticky: TIMEOUT reached
err_beats  out  1  sticky: beat-count mismatch

Behaviour:
- Reset: state S_IDLE; all m_* outputs 0, all cache strobes 0, errors 0, counters 0. Reset asserted mid-burst aborts immediately; no completion pulse is issued.
- FSM states: S_IDLE, S_ICACHE, S_DCACHE, S_GAP.
- S_IDLE:
  - d_rw_valid and not starve → S_DCACHE.
  - Otherwise i_rw_valid → S_ICACHE.
  - Otherwise stay.
  - starve = (consec_d == MAX_CONSEC) and i_rw_valid.
- Grant latency: the request is seen in S_IDLE and m_rw_valid is first driven the next cycle, so there is one cycle of arbitration latency.
- Owner state: m_* carries the owner's signals combinationally; m_rw_valid = owner valid. Icache drives m_rw_req = REQ_READ, m_w_strb = 0, m_w_last = 0.
- Response routing: m_rw_ready, r_hs, r_last, w_hs and axi_write_ahead are routed only to the owner; the non-owner sees 0. data_read = m_data_read unconditionally.
- m_rw_ready in an owner state → S_GAP. S_GAP lasts exactly one cycle with m_rw_valid = 0, which absorbs the owner's registered valid drop. S_GAP → S_IDLE.
- consec_d:
  - increments on entry to S_DCACHE while i_rw_valid is high (saturates at MAX_CONSEC);
  - clears on entry to S_ICACHE or when i_rw_valid is low in S_IDLE.
- Beat counter:
  - cleared on grant; increments on m_r_hs or m_w_hs;
  - err_beats is set if the final beat (r_last, or w_hs with m_w_last) occurs with beat_cnt != latched len, or if beat_cnt would exceed len.
  - An uncacheable access (len 0) counts one beat.
- Watchdog: counts cycles in owner states and clears on grant. At TIMEOUT it sets err_timeout; the grant stays held, with no forced release.
- err_clr clears both sticky errors. If an error event and err_clr occur in the same cycle, the error wins (stays set).
- m_rw_ready arriving in S_IDLE or S_GAP is ignored.

Optional Feature:
YSYX_22040632_ARB_PERF_CNT_EN:
- Defined: adds 32-bit outputs perf_i_grants, perf_d_grants and perf_i_wait_cycles. The wait counter counts cycles with i_rw_valid high while not in S_ICACHE. Counters wrap and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gains the arbiter state enum (arb_state_e) and owner enum (OWN_I, OWN_D).
- REQ_READ/REQ_WRITE come from the existing riscv package.
- One sub-module: ysyx_22040632_arb_monitor, containing the beat counter, watchdog and sticky errors. It is fed grant, len, the beat strobes and the last-beat strobes.

Test Plan:
- i_rw_valid alone, len 7, 8 r_hs with r_last on the 8th, then rw_ready → m_rw_valid rises 1 cycle after the request; i_rw_ready pulses once; S_GAP follows for 1 cycle; err_beats stays 0.
- i and d valid in the same cycle → dcache granted first; icache granted after d_rw_ready + 1 gap cycle; d_rw_ready never reaches the icache.
- Dcache requests back-to-back while icache waits, MAX_CONSEC = 4 → 4 dcache grants, then the icache is granted on the 5th arbitration.
- Dcache write, len 7, d_w_last on the 6th w_hs → err_beats = 1. err_clr → 0.
- Owner holds for TIMEOUT = 16 cycles without m_rw_ready → err_timeout = 1 at cycle 16; grant is retained; a later rw_ready returns the FSM to idle.
- rrst pulsed mid-burst during an icache grant → all outputs 0 the same cycle; the next request is re-arbitrated from S_IDLE.

Source files
------------

// File: rtl/ysyx_22040632_mem_arbiter_pkg.sv
// Shared types for the cache-side memory port arbiter.
package ysyx_22040632_mem_arbiter_pkg;

  // Request direction encoding, matching the riscv package.
  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ICACHE = 2'd1,
    S_DCACHE = 2'd2,
    S_GAP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22040632_mem_arbiter_if.sv
// rw_* burst port bundle. The cache (or arbiter, downstream) is master; the responder is slave.
interface ysyx_22040632_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic            rw_valid;
  logic            rw_req;
  logic [AW-1:0]   rw_addr;
  logic [2:0]      rw_size;
  logic [7:0]      rw_len;
  logic [DW-1:0]   rw_w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_last;

  logic            rw_ready;
  logic            r_hs;
  logic            r_last;
  logic            w_hs;
  logic            axi_write_ahead;
  logic [DW-1:0]   data_read;

  modport master (
    output rw_valid, rw_req, rw_addr, rw_size, rw_len, rw_w_data, w_strb, w_last,
    input  rw_ready, r_hs, r_last, w_hs, axi_write_ahead, data_read
  );

  modport slave (
    input  rw_valid, rw_req, rw_addr, rw_size, rw_len, rw_w_data, w_strb, w_last,
    output rw_ready, r_hs, r_last, w_hs, axi_write_ahead, data_read
  );
endinterface

// File: rtl/ysyx_22040632_mem_arbiter_monitor.sv
// Per-transaction beat counter and watchdog with sticky error flags.
module ysyx_22040632_arb_monitor
  import ysyx_22040632_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rrst,
  input  logic       grant,
  input  logic [7:0] len,
  input  logic       busy,
  input  logic       beat,
  input  logic       last_beat,
  input  logic       err_clr,
  output logic       err_timeout,
  output logic       err_beats
);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [7:0]    len_q, len_d;
  logic [8:0]    beat_q, beat_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_t_q, err_t_d;
  logic          err_b_q, err_b_d;
  logic          to_evt, beat_evt;

  always_comb begin
    len_d    = len_q;
    beat_d   = beat_q;
    wdog_d   = wdog_q;
    to_evt   = 1'b0;
    beat_evt = 1'b0;
    if (grant) begin
      len_d  = len;
      beat_d = '0;
      wdog_d = '0;
    end else if (busy) begin
      if (wdog_q != WW'(TIMEOUT)) begin
        wdog_d = wdog_q + WW'(1);
        to_evt = (wdog_d == WW'(TIMEOUT));
      end
      // beat_q is the index of the current beat; legal indices are 0..len
      if (beat) begin
        if (beat_q > {1'b0, len_q}) beat_evt = 1'b1;
        if (last_beat && (beat_q != {1'b0, len_q})) beat_evt = 1'b1;
        if (beat_q != '1) beat_d = beat_q + 9'd1;
      end
    end
    err_t_d = to_evt   | (err_t_q & ~err_clr);
    err_b_d = beat_evt | (err_b_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      len_q   <= '0;
      beat_q  <= '0;
      wdog_q  <= '0;
      err_t_q <= 1'b0;
      err_b_q <= 1'b0;
    end else begin
      len_q   <= len_d;
      beat_q  <= beat_d;
      wdog_q  <= wdog_d;
      err_t_q <= err_t_d;
      err_b_q <= err_b_d;
    end
  end

  assign err_timeout = err_t_q;
  assign err_beats   = err_b_q;

endmodule

// File: rtl/ysyx_22040632_mem_arbiter.sv
// Shares the cache-side memory port between icache and dcache with anti-starvation.
// Optional perf counters enabled by defining YSYX_22040632_ARB_PERF_CNT_EN.
//   state    | meaning
//   S_IDLE   | no owner, arbitrate
//   S_ICACHE | icache owns the port
//   S_DCACHE | dcache owns the port
//   S_GAP    | one dead cycle after completion
module ysyx_22040632_mem_arbiter
  import ysyx_22040632_mem_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 4096,
  parameter int AW         = 32,
  parameter int DW         = 64
) (
  input  logic clk,
  input  logic rrst,
  ysyx_22040632_mem_arbiter_if.slave  i_port,
  ysyx_22040632_mem_arbiter_if.slave  d_port,
  ysyx_22040632_mem_arbiter_if.master m_port,
  input  logic err_clr,
  output logic err_timeout,
  output logic err_beats
`ifdef YSYX_22040632_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_i_wait_cycles
`endif
);
  localparam int CW = $clog2(MAX_CONSEC + 1);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            starve, grant_i, grant_d, own_i, own_d;
  owner_e          grant_own;
  logic [7:0]      grant_len;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_strb;
  logic            own_w_last, last_beat;

  always_comb begin
    starve   = (consec_q == CW'(MAX_CONSEC)) && i_port.rw_valid;
    state_d  = state_q;
    consec_d = consec_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!i_port.rw_valid) consec_d = '0;
        if (d_port.rw_valid && !starve) begin
          state_d = S_DCACHE;
          grant_d = 1'b1;
          if (i_port.rw_valid && (consec_q != CW'(MAX_CONSEC))) consec_d = consec_q + CW'(1);
        end else if (i_port.rw_valid) begin
          state_d  = S_ICACHE;
          grant_i  = 1'b1;
          consec_d = '0;
        end
      end
      S_ICACHE: if (m_port.rw_ready) state_d = S_GAP;
      S_DCACHE: if (m_port.rw_ready) state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      state_q  <= S_IDLE;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
    end
  end

  // Request mux: everything is zero outside the two owner states.
  always_comb begin
    own_i      = (state_q == S_ICACHE);
    own_d      = (state_q == S_DCACHE);
    own_addr   = own_i ? i_port.rw_addr   : (own_d ? d_port.rw_addr   : '0);
    own_wdata  = own_i ? i_port.rw_w_data : (own_d ? d_port.rw_w_data : '0);
    own_strb   = own_d ? d_port.w_strb : '0;
    own_w_last = own_d & d_port.w_last;

    m_port.rw_valid  = (own_i & i_port.rw_valid) | (own_d & d_port.rw_valid);
    m_port.rw_req    = own_d ? d_port.rw_req : REQ_READ;
    m_port.rw_addr   = own_addr;
    m_port.rw_size   = own_i ? i_port.rw_size : (own_d ? d_port.rw_size : 3'd0);
    m_port.rw_len    = own_i ? i_port.rw_len  : (own_d ? d_port.rw_len  : 8'd0);
    m_port.rw_w_data = own_wdata;
    m_port.w_strb    = own_strb;
    m_port.w_last    = own_w_last;

    i_port.rw_ready        = own_i & m_port.rw_ready;
    i_port.r_hs            = own_i & m_port.r_hs;
    i_port.r_last          = own_i & m_port.r_last;
    i_port.w_hs            = own_i & m_port.w_hs;
    i_port.axi_write_ahead = own_i & m_port.axi_write_ahead;
    i_port.data_read       = m_port.data_read;

    d_port.rw_ready        = own_d & m_port.rw_ready;
    d_port.r_hs            = own_d & m_port.r_hs;
    d_port.r_last          = own_d & m_port.r_last;
    d_port.w_hs            = own_d & m_port.w_hs;
    d_port.axi_write_ahead = own_d & m_port.axi_write_ahead;
    d_port.data_read       = m_port.data_read;

    grant_own = grant_d ? OWN_D : OWN_I;
    grant_len = (grant_own == OWN_D) ? d_port.rw_len : i_port.rw_len;
    last_beat = (m_port.r_hs & m_port.r_last) | (m_port.w_hs & own_w_last);
  end

  ysyx_22040632_arb_monitor #(
    .TIMEOUT(TIMEOUT)
  ) u_monitor (
    .clk        (clk),
    .rrst       (rrst),
    .grant      (grant_i | grant_d),
    .len        (grant_len),
    .busy       (own_i | own_d),
    .beat       (m_port.r_hs | m_port.w_hs),
    .last_beat  (last_beat),
    .err_clr    (err_clr),
    .err_timeout(err_timeout),
    .err_beats  (err_beats)
  );

`ifdef YSYX_22040632_ARB_PERF_CNT_EN
  logic [31:0] perf_ig_q, perf_ig_d, perf_dg_q, perf_dg_d, perf_iw_q, perf_iw_d;

  always_comb begin
    perf_ig_d = perf_ig_q + {31'd0, grant_i};
    perf_dg_d = perf_dg_q + {31'd0, grant_d};
    perf_iw_d = perf_iw_q + {31'd0, (i_port.rw_valid && (state_q != S_ICACHE))};
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      perf_ig_q <= '0;
      perf_dg_q <= '0;
      perf_iw_q <= '0;
    end else begin
      perf_ig_q <= perf_ig_d;
      perf_dg_q <= perf_dg_d;
      perf_iw_q <= perf_iw_d;
    end
  end

  assign perf_i_grants      = perf_ig_q;
  assign perf_d_grants      = perf_dg_q;
  assign perf_i_wait_cycles = perf_iw_q;
`endif

endmodule
